// File: rtl/swipt_pkg.sv
// swipt_pkg
// Shared types and helpers for the SWIPT FSK transmitter.
//   - Default clock, centre-frequency and deviation values.
//   - half_period(): elaboration-time rounded half-period in clk cycles.
//   - bit_sel(): maps a data bit to its carrier frequency select.
//   - state_t: transmitter FSM states.
//   - freq_sel_t: carrier frequency select (f0, f0+delf, f0-delf).
package swipt_pkg;

  localparam int unsigned CLK_HZ_DEF  = 100_000_000;
  localparam int unsigned F0_HZ_DEF   = 39_000;
  localparam int unsigned DELF_HZ_DEF = 12_000;

  typedef enum logic [1:0] {
    OFF,
    PRE,
    IDLE_C,
    SYM
  } state_t;

  typedef enum logic [1:0] {
    SEL_F0,
    SEL_HI,
    SEL_LO
  } freq_sel_t;

  // round(clk / (2f)) computed as floor((clk + f) / (2f)); 64-bit to avoid overflow.
  function automatic int unsigned half_period(input int unsigned clk_hz,
                                              input int unsigned f_hz);
    logic [63:0] num;
    logic [63:0] den;
    num = 64'(clk_hz) + 64'(f_hz);
    den = 64'(f_hz) << 1;
    return 32'(num / den);
  endfunction

  function automatic freq_sel_t bit_sel(input logic b);
    return b ? SEL_HI : SEL_LO;
  endfunction

endpackage

// File: rtl/swipt_carrier_gen.sv
// swipt_carrier_gen
// Phase-continuous square-wave carrier with a per-period selectable half-period.
// Ports:
//   clk, nrst      clock, synchronous active-high reset
//   run            carrier enabled; low holds link at 0 and clears the counter
//   sel            frequency select, sampled only at a period start
//   h0, hh, hl     half-periods (clk cycles) for f0, f0+delf, f0-delf
//   link           carrier output, high phase first
//   period_start   combinational: the coming clk edge is a rising toggle
//   f              frequency in Hz of the current carrier period
module swipt_carrier_gen
  import swipt_pkg::*;
#(
  parameter int          HW      = 16,
  parameter int unsigned F0_HZ   = F0_HZ_DEF,
  parameter int unsigned DELF_HZ = DELF_HZ_DEF
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          run,
  input  freq_sel_t     sel,
  input  logic [HW-1:0] h0,
  input  logic [HW-1:0] hh,
  input  logic [HW-1:0] hl,
  output logic          link,
  output logic          period_start,
  output logic [31:0]   f
);

  logic [HW-1:0] hcnt;
  logic [HW-1:0] hcur;
  logic [HW-1:0] hsel;
  logic [31:0]   fsel;

  always_comb begin
    hsel = h0;
    fsel = F0_HZ;
    case (sel)
      SEL_HI: begin
        hsel = hh;
        fsel = F0_HZ + DELF_HZ;
      end
      SEL_LO: begin
        hsel = hl;
        fsel = F0_HZ - DELF_HZ;
      end
      default: ;
    endcase
  end

  // The idle state (link=0, hcnt=0) makes the very first toggle after run
  // rises a rising one, so start-up needs no special case.
  assign period_start = run && !link && (hcnt == '0);

  always_ff @(posedge clk) begin
    if (nrst || !run) begin
      link <= 1'b0;
      hcnt <= '0;
      hcur <= h0;
      f    <= F0_HZ;
    end else if (period_start) begin
      link <= 1'b1;
      hcnt <= hsel - HW'(1);
      hcur <= hsel;
      f    <= fsel;
    end else if (hcnt == '0) begin
      // Falling toggle keeps the half-period chosen at the period start.
      link <= 1'b0;
      hcnt <= hcur - HW'(1);
    end else begin
      hcnt <= hcnt - HW'(1);
    end
  end

endmodule

// File: rtl/swipt_fsk_tx.sv
// swipt_fsk_tx
// Transmit end of the SWIPT link: f0 preamble, then LSB-first binary FSK bytes.
// Ports:
//   clk, nrst     clock, synchronous active-high reset
//   en            transmitter enable; low acts as a synchronous soft reset
//   s_data        byte to send, sampled on the handshake edge
//   s_valid       byte valid
//   s_ready       byte accept (transfer when s_valid && s_ready)
//   link          FSK carrier
//   freq_rdy      high during the preamble
//   swipt_alive   high whenever the carrier runs
//   busy          a byte is buffered or being transmitted
//   f             frequency in Hz of the current carrier period
module swipt_fsk_tx
  import swipt_pkg::*;
#(
  parameter int unsigned CLK_HZ      = CLK_HZ_DEF,
  parameter int unsigned F0_HZ       = F0_HZ_DEF,
  parameter int unsigned DELF_HZ     = DELF_HZ_DEF,
  parameter int unsigned PRE_PERIODS = 16,
  parameter int unsigned SYM_PERIODS = 8,
  parameter int          HW          = 16
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        en,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        link,
  output logic        freq_rdy,
  output logic        swipt_alive,
  output logic        busy,
  output logic [31:0] f
);

  localparam int unsigned PMAX = (PRE_PERIODS > SYM_PERIODS) ? PRE_PERIODS : SYM_PERIODS;
  localparam int          PW   = $clog2(PMAX + 1);

  localparam logic [HW-1:0] H0 = HW'(half_period(CLK_HZ, F0_HZ));
  localparam logic [HW-1:0] HH = HW'(half_period(CLK_HZ, F0_HZ + DELF_HZ));
  localparam logic [HW-1:0] HL = HW'(half_period(CLK_HZ, F0_HZ - DELF_HZ));

  state_t      state;
  logic [PW-1:0] pcnt;
  logic [2:0]  bidx;
  logic [7:0]  shift;
  logic [7:0]  buffer;
  logic        pend;
  logic        period_start;
  freq_sel_t   sel;
  logic        handshake;
  logic        pre_done;
  logic        bit_done;

  assign handshake = s_valid && s_ready;
  assign pre_done  = (pcnt == PW'(PRE_PERIODS));
  assign bit_done  = (pcnt == PW'(SYM_PERIODS));

  swipt_carrier_gen #(
    .HW      (HW),
    .F0_HZ   (F0_HZ),
    .DELF_HZ (DELF_HZ)
  ) u_carrier (
    .clk          (clk),
    .nrst         (nrst),
    .run          (en),
    .sel          (sel),
    .h0           (H0),
    .hh           (HH),
    .hl           (HL),
    .link         (link),
    .period_start (period_start),
    .f            (f)
  );

  // Frequency of the period that would start on the coming edge. Only the
  // registered pend is looked at, so a handshake landing on a period start
  // delays the symbol by one f0 period.
  always_comb begin
    sel = SEL_F0;
    case (state)
      IDLE_C: if (pend) sel = bit_sel(buffer[0]);
      SYM: begin
        if (!bit_done)         sel = bit_sel(shift[0]);
        else if (bidx != 3'd7) sel = bit_sel(shift[1]);
        else if (pend)         sel = bit_sel(buffer[0]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (nrst || !en) begin
      state       <= OFF;
      pcnt        <= '0;
      bidx        <= 3'd0;
      shift       <= 8'd0;
      buffer      <= 8'd0;
      pend        <= 1'b0;
      s_ready     <= 1'b0;
      busy        <= 1'b0;
      freq_rdy    <= 1'b0;
      swipt_alive <= 1'b0;
    end else begin
      case (state)
        OFF: begin
          // The carrier starts its first period on this same edge.
          state       <= PRE;
          pcnt        <= PW'(1);
          freq_rdy    <= 1'b1;
          swipt_alive <= 1'b1;
        end
        PRE: begin
          if (period_start) begin
            if (pre_done) begin
              state    <= IDLE_C;
              pcnt     <= '0;
              freq_rdy <= 1'b0;
              s_ready  <= 1'b1;
            end else begin
              pcnt <= pcnt + PW'(1);
            end
          end
        end
        IDLE_C: begin
          if (period_start && pend) begin
            state <= SYM;
            pcnt  <= PW'(1);
            bidx  <= 3'd0;
            shift <= buffer;
            pend  <= 1'b0;
          end
        end
        SYM: begin
          if (period_start) begin
            if (!bit_done) begin
              pcnt <= pcnt + PW'(1);
            end else if (bidx == 3'd7) begin
              if (pend) begin
                // Next byte follows with no f0 gap.
                pcnt  <= PW'(1);
                bidx  <= 3'd0;
                shift <= buffer;
                pend  <= 1'b0;
              end else begin
                state   <= IDLE_C;
                pcnt    <= '0;
                busy    <= 1'b0;
                s_ready <= 1'b1;
              end
            end else begin
              pcnt  <= PW'(1);
              bidx  <= bidx + 3'd1;
              shift <= {1'b0, shift[7:1]};
              // Open the skid buffer as bit 7 begins.
              if (bidx == 3'd6 && !pend) s_ready <= 1'b1;
            end
          end
        end
        default: state <= OFF;
      endcase
      // Accepting a byte overrides any ready/busy update made above.
      if (handshake) begin
        buffer  <= s_data;
        pend    <= 1'b1;
        s_ready <= 1'b0;
        busy    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_swipt_fsk_tx.sv
// tb_swipt_fsk_tx
// Directed bench for swipt_fsk_tx. A default-parameter instance checks the
// real-rate preamble timing; a fast instance (1 MHz clk, 4-period preamble,
// 2 periods per bit) checks framing, FSK data, skid buffering and aborts.
// Fast instance half-periods: round(1e6/78000)=13, round(1e6/102000)=10,
// round(1e6/54000)=19, giving periods of 26, 20 and 38 cycles.
module tb_swipt_fsk_tx;

  localparam logic [31:0] F_MID = 32'd39000;
  localparam logic [31:0] F_HI  = 32'd51000;
  localparam logic [31:0] F_LO  = 32'd27000;
  localparam int P_MID = 26;
  localparam int P_HI  = 20;
  localparam int P_LO  = 38;
  localparam int SYM_P = 2;
  localparam int TMO   = 200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;
  int last_rise = 0;
  logic [31:0] prev_f = F_MID;

  // fast instance
  logic        nrst, en, s_valid, s_ready, link, freq_rdy, swipt_alive, busy;
  logic [7:0]  s_data;
  logic [31:0] f;

  // default-parameter instance
  logic        d_nrst, d_en, d_s_valid, d_s_ready, d_link, d_freq_rdy, d_swipt_alive, d_busy;
  logic [7:0]  d_s_data;
  logic [31:0] d_f;

  swipt_fsk_tx #(
    .CLK_HZ      (1_000_000),
    .PRE_PERIODS (4),
    .SYM_PERIODS (2)
  ) u_dut (
    .clk         (clk),
    .nrst        (nrst),
    .en          (en),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .link        (link),
    .freq_rdy    (freq_rdy),
    .swipt_alive (swipt_alive),
    .busy        (busy),
    .f           (f)
  );

  swipt_fsk_tx u_def (
    .clk         (clk),
    .nrst        (d_nrst),
    .en          (d_en),
    .s_data      (d_s_data),
    .s_valid     (d_s_valid),
    .s_ready     (d_s_ready),
    .link        (d_link),
    .freq_rdy    (d_freq_rdy),
    .swipt_alive (d_swipt_alive),
    .busy        (d_busy),
    .f           (d_f)
  );

  function automatic int periodOf(input logic [31:0] fr);
    if (fr == F_HI) return P_HI;
    if (fr == F_LO) return P_LO;
    return P_MID;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input int cycles);
    nrst = r;
    en   = e;
    repeat (cycles) @(negedge clk);
  endtask

  // Waits (bounded) for the next rising edge of link, seen at a negedge.
  task automatic waitRise(output logic [31:0] fv);
    logic prev;
    bit   seen;
    prev = link;
    seen = 0;
    for (int n = 0; n < TMO && !seen; n++) begin
      @(negedge clk);
      if (link && !prev) seen = 1;
      prev = link;
    end
    checkOutput("rise_seen", 32'(seen), 32'd1);
    fv = f;
  endtask

  task automatic expectPeriod(input string tag, input logic [31:0] fexp,
                              input logic busy_exp, input logic rdy_exp);
    logic [31:0] fv;
    waitRise(fv);
    checkOutput({tag, "_len"}, 32'(cyc - last_rise), 32'(periodOf(prev_f)));
    checkOutput({tag, "_f"}, fv, fexp);
    checkOutput({tag, "_busy"}, 32'(busy), 32'(busy_exp));
    checkOutput({tag, "_rdy"}, 32'(s_ready), 32'(rdy_exp));
    last_rise = cyc;
    prev_f    = fexp;
  endtask

  // First nper bit-periods of byte b; ready reopens at bit 7 unless the
  // next byte is taken right away.
  task automatic expectBits(input string tag, input logic [7:0] b, input int nper, input bit more);
    logic bv;
    logic rdy;
    for (int p = 0; p < nper; p++) begin
      bv  = b[p / SYM_P];
      rdy = (p >= 14) && !(p == 15 && more);
      expectPeriod(tag, bv ? F_HI : F_LO, 1'b1, rdy);
    end
  endtask

  task automatic sendByte(input logic [7:0] b);
    bit seen;
    s_data  = b;
    s_valid = 1'b1;
    seen    = 0;
    for (int n = 0; n < 2000 && !seen; n++) begin
      if (s_ready) seen = 1;
      @(negedge clk);
    end
    checkOutput("hs_seen", 32'(seen), 32'd1);
  endtask

  task automatic checkPreamble(input string tag);
    @(negedge clk);
    checkOutput({tag, "_link"}, 32'(link), 32'd1);
    checkOutput({tag, "_frdy"}, 32'(freq_rdy), 32'd1);
    checkOutput({tag, "_alive"}, 32'(swipt_alive), 32'd1);
    checkOutput({tag, "_f0"}, f, F_MID);
    last_rise = cyc;
    prev_f    = F_MID;
    for (int i = 1; i <= 4; i++) begin
      expectPeriod(tag, F_MID, 1'b0, i == 4);
      checkOutput({tag, "_frdy_p"}, 32'(freq_rdy), 32'(i < 4));
    end
  endtask

  task automatic checkOff(input string tag);
    checkOutput({tag, "_link"}, 32'(link), 32'd0);
    checkOutput({tag, "_rdy"}, 32'(s_ready), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_frdy"}, 32'(freq_rdy), 32'd0);
    checkOutput({tag, "_alive"}, 32'(swipt_alive), 32'd0);
    checkOutput({tag, "_f"}, f, F_MID);
  endtask

  initial begin
    int hi, lo, total;
    nrst = 1'b1; en = 1'b0; s_valid = 1'b0; s_data = 8'd0;
    d_nrst = 1'b1; d_en = 1'b0; d_s_valid = 1'b0; d_s_data = 8'd0;

    // Default rates: H0=1282, preamble 16*2564 = 41024 cycles.
    repeat (3) @(negedge clk);
    checkOutput("d_rst_link", 32'(d_link), 32'd0);
    checkOutput("d_rst_f", d_f, F_MID);
    d_nrst = 1'b0;
    d_en   = 1'b1;
    @(negedge clk);
    checkOutput("d_start_link", 32'(d_link), 32'd1);
    checkOutput("d_start_frdy", 32'(d_freq_rdy), 32'd1);
    hi = 0;
    while (d_link && hi < 5000) begin hi++; @(negedge clk); end
    lo = 0;
    while (!d_link && lo < 5000) begin lo++; @(negedge clk); end
    checkOutput("d_half_hi", 32'(hi), 32'd1282);
    checkOutput("d_half_lo", 32'(lo), 32'd1282);
    total = hi + lo;
    while (d_freq_rdy && total < 50000) begin total++; @(negedge clk); end
    checkOutput("d_pre_len", 32'(total), 32'd41024);
    checkOutput("d_pre_rdy", 32'(d_s_ready), 32'd1);
    checkOutput("d_pre_link", 32'(d_link), 32'd1);
    checkOutput("d_pre_f", d_f, F_MID);
    d_en = 1'b0;

    // Reset held with en=1, then release: link rises one cycle later.
    applyStimulus(1'b1, 1'b1, 5);
    checkOff("rst");
    applyStimulus(1'b0, 1'b1, 0);
    checkPreamble("pre");

    // Single byte 0xA5.
    fork
      begin sendByte(8'hA5); s_valid = 1'b0; end
      expectBits("a5", 8'hA5, 16, 1'b0);
    join
    expectPeriod("a5_end", F_MID, 1'b0, 1'b1);
    expectPeriod("idle", F_MID, 1'b0, 1'b1);

    // Back-to-back 0xFF, 0x00 with s_valid held.
    fork
      begin sendByte(8'hFF); sendByte(8'h00); s_valid = 1'b0; end
      begin expectBits("ff", 8'hFF, 16, 1'b1); expectBits("z", 8'h00, 16, 1'b0); end
    join
    expectPeriod("b2b_end", F_MID, 1'b0, 1'b1);

    // Handshake on the same edge as a period start: one extra f0 period.
    repeat (P_MID - 1) @(negedge clk);
    checkOutput("co_pre_link", 32'(link), 32'd0);
    s_data  = 8'h0F;
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    checkOutput("co_link", 32'(link), 32'd1);
    checkOutput("co_f", f, F_MID);
    checkOutput("co_busy", 32'(busy), 32'd1);
    checkOutput("co_rdy", 32'(s_ready), 32'd0);
    last_rise = cyc;
    prev_f    = F_MID;
    expectBits("co", 8'h0F, 7, 1'b0);

    // en=0 during bit 3.
    en = 1'b0;
    @(negedge clk);
    checkOff("en_off");
    applyStimulus(1'b0, 1'b0, 3);
    applyStimulus(1'b0, 1'b1, 0);
    checkPreamble("re_en");
    expectPeriod("re_en_idle", F_MID, 1'b0, 1'b1);

    // Same abort with nrst.
    fork
      begin sendByte(8'h0F); s_valid = 1'b0; end
      expectBits("rb", 8'h0F, 7, 1'b0);
    join
    applyStimulus(1'b1, 1'b1, 1);
    checkOff("rst_off");
    applyStimulus(1'b0, 1'b1, 0);
    checkPreamble("re_rst");
    expectPeriod("re_rst_idle", F_MID, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
